// File: rtl/therm_vec_gen_if.sv
// Handshake/data bundle between a sequencing controller and therm_vec_gen.
//   start      controller -> generator  one-cycle request to begin a sequence
//   stop       controller -> generator  abort the running sequence
//   out_vec    generator  -> sink       thermometer pattern (WIDTH bits)
//   out_valid  generator  -> sink       out_vec carries a sequence pattern
//   busy       generator  -> controller sequence running
//   done       generator  -> controller one-cycle end-of-sequence pulse
// master: the controller side; slave: the generator.
interface therm_vec_gen_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic             stop;
  logic [WIDTH-1:0] out_vec;
  logic             out_valid;
  logic             busy;
  logic             done;

  modport master (
    output start,
    output stop,
    input  out_vec,
    input  out_valid,
    input  busy,
    input  done
  );

  modport slave (
    input  start,
    input  stop,
    output out_vec,
    output out_valid,
    output busy,
    output done
  );
endinterface

// File: rtl/therm_vec_gen.sv
// Registered thermometer-code stimulus source (01, 03, 07 ... all-ones).
// Every output comes straight from a flop, so the downstream capture stage
// only ever sees changes right after posedge clk.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    therm_vec_gen_if.slave: start/stop in; out_vec/out_valid/busy/done out
//
// state | meaning
// IDLE  | waiting for start; out_vec keeps its last value, out_valid low
// RUN   | stepping patterns, each held HOLD_CYCLES clocks
// DONE  | one-cycle done pulse after all-ones (non-wrapping only)
module therm_vec_gen #(
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2,
  parameter bit WRAP        = 1'b0
) (
  input  logic               clk,
  input  logic               rst_n,
  therm_vec_gen_if.slave     bus
);

  if (WIDTH < 2) begin : g_bad_width
    $error("therm_vec_gen: WIDTH must be >= 2");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("therm_vec_gen: HOLD_CYCLES must be >= 1");
  end

  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [CW-1:0]    HOLD_RELOAD = CW'(HOLD_CYCLES - 1);
  localparam logic [WIDTH-1:0] VEC_FIRST   = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] VEC_ALL     = {WIDTH{1'b1}};

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] vec_q, vec_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CW-1:0]    hold_cnt_q, hold_cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      vec_q      <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      vec_q      <= vec_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    vec_d      = vec_q;
    valid_d    = valid_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    hold_cnt_d = hold_cnt_q;

    unique case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_d    = RUN;
          vec_d      = VEC_FIRST;
          valid_d    = 1'b1;
          busy_d     = 1'b1;
          hold_cnt_d = HOLD_RELOAD;
        end
      end

      RUN: begin
        if (bus.stop) begin
          // Abort wins over everything, including the final step.
          state_d    = IDLE;
          vec_d      = '0;
          valid_d    = 1'b0;
          busy_d     = 1'b0;
          hold_cnt_d = '0;
        end else if (hold_cnt_q != '0) begin
          hold_cnt_d = hold_cnt_q - CW'(1);
        end else if (vec_q != VEC_ALL) begin
          vec_d      = {vec_q[WIDTH-2:0], 1'b1};
          hold_cnt_d = HOLD_RELOAD;
        end else if (WRAP) begin
          vec_d      = VEC_FIRST;
          hold_cnt_d = HOLD_RELOAD;
        end else begin
          // All-ones stays on the bus; only valid/busy drop.
          state_d = DONE;
          done_d  = 1'b1;
          valid_d = 1'b0;
          busy_d  = 1'b0;
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d    = IDLE;
        vec_d      = '0;
        valid_d    = 1'b0;
        busy_d     = 1'b0;
        hold_cnt_d = '0;
      end
    endcase
  end

  assign bus.out_vec   = vec_q;
  assign bus.out_valid = valid_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;

endmodule
